// File: rtl/register_file_16.sv
// register_file_16: sixteen-entry N-bit register file, one synchronous write port, two combinational read ports

// mux4: four-way word selector, the building block of each read tree
module mux4 #(
    parameter int N = 16
) (
    input  logic [4*N-1:0] d_i,
    input  logic [1:0]     sel_i,
    output logic [N-1:0]   y_o
);
    // pick word sel_i out of the packed input bus
    always_comb y_o = d_i[sel_i*N +: N];
endmodule

// mux16: sixteen-way word selector built as two levels of mux4
module mux16 #(
    parameter int N = 16
) (
    input  logic [16*N-1:0] d_i,
    input  logic [3:0]      sel_i,
    output logic [N-1:0]    y_o
);
    logic [4*N-1:0] mid;
    for (genvar g = 0; g < 4; g++) begin : g_lvl0
        mux4 #(.N(N)) u_m (
            .d_i  (d_i[g*4*N +: 4*N]),
            .sel_i(sel_i[1:0]),
            .y_o  (mid[g*N +: N])
        );
    end
    mux4 #(.N(N)) u_top (
        .d_i  (mid),
        .sel_i(sel_i[3:2]),
        .y_o  (y_o)
    );
endmodule

// dec4to16: one-hot write decoder, all-zero when not enabled
module dec4to16 (
    input  logic        ena_i,
    input  logic [3:0]  addr_i,
    output logic [15:0] en_o
);
    // a single bit set at the addressed entry only while writing
    always_comb en_o = ena_i ? (16'd1 << addr_i) : 16'd0;
endmodule

// register_file_16: storage plus two independent read trees
module register_file_16 #(
    parameter int N        = 16,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [3:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [3:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [3:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);
    logic [15:0]     dec_en;
    logic [15:0]     wr_en;
    logic [N-1:0]    r_q [16];
    logic [N-1:0]    r_d [16];
    logic [16*N-1:0] rf_bus;

    dec4to16 u_dec (
        .ena_i (wr_ena),
        .addr_i(wr_addr),
        .en_o  (dec_en)
    );

    assign wr_en = (ZERO_REG != 0) ? {dec_en[15:1], 1'b0} : dec_en;

    // each entry loads write data only when its decoder bit is set
    always_comb begin
        for (int i = 0; i < 16; i++) r_d[i] = wr_en[i] ? wr_data : r_q[i];
    end

    // reset clears the whole file at once, independent of the clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_bus
        assign rf_bus[g*N +: N] = (g == 0 && ZERO_REG != 0) ? '0 : r_q[g];
    end

    mux16 #(.N(N)) u_rd0 (
        .d_i  (rf_bus),
        .sel_i(rd_addr0),
        .y_o  (rd_data0)
    );

    mux16 #(.N(N)) u_rd1 (
        .d_i  (rf_bus),
        .sel_i(rd_addr1),
        .y_o  (rd_data1)
    );
endmodule

// File: tb/tb_register_file_16.sv
// tb_register_file_16: table-driven and scoreboard checks of the register file
`timescale 1ns/10ps
module tb_register_file_16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_ena = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [15:0] wr_data = 16'd0;
    logic [3:0]  rd_addr0 = 4'd0;
    logic [3:0]  rd_addr1 = 4'd0;
    logic [15:0] rd_data0, rd_data1, b_data0, b_data1;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    typedef struct {
        int          tag;
        logic [15:0] e0;
        logic [15:0] e1;
    } exp_t;

    vec_t tbl [12];
    exp_t sb [$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    register_file_16 #(.N(16), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_addr1(rd_addr1), .rd_data1(rd_data1)
    );

    register_file_16 #(.N(16), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(b_data0), .rd_addr1(rd_addr1), .rd_data1(b_data1)
    );

    task automatic cmp(input string nm, input int tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, tag, act, exp);
        end
    endtask

    task automatic apply(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [3:0] a0, input logic [3:0] a1);
        @(negedge clk);
        wr_ena = we;
        wr_addr = wa;
        wr_data = wd;
        rd_addr0 = a0;
        rd_addr1 = a1;
    endtask

    task automatic expect2(input int tag, input logic [15:0] e0, input logic [15:0] e1);
        exp_t x;
        x.tag = tag;
        x.e0 = e0;
        x.e1 = e1;
        sb.push_back(x);
    endtask

    task automatic drain(input string nm);
        exp_t x;
        #0.1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            total--;
            x = sb.pop_front();
            cmp({nm, "_p0"}, x.tag, rd_data0, x.e0);
            cmp({nm, "_p1"}, x.tag, rd_data1, x.e1);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 4'd7, 16'hDEAD, 4'd0, 4'd7, 16'h0000, 16'hA007};
        tbl[2]  = '{1'b0, 4'd7, 16'hDEAD, 4'd7, 4'd7, 16'hA007, 16'hA007};
        tbl[3]  = '{1'b0, 4'd7, 16'hDEAD, 4'd7, 4'd0, 16'hA007, 16'h0000};
        tbl[4]  = '{1'b0, 4'd7, 16'hDEAD, 4'd7, 4'd7, 16'hA007, 16'hA007};
        tbl[5]  = '{1'b1, 4'd5, 16'h1111, 4'd5, 4'd7, 16'hA005, 16'hA007};
        tbl[6]  = '{1'b1, 4'd5, 16'h2222, 4'd5, 4'd5, 16'h1111, 16'h1111};
        tbl[7]  = '{1'b0, 4'd5, 16'h0000, 4'd5, 4'd5, 16'h2222, 16'h2222};
        tbl[8]  = '{1'b1, 4'd9, 16'h0001, 4'd9, 4'd9, 16'hA009, 16'hA009};
        tbl[9]  = '{1'b1, 4'd9, 16'h0002, 4'd9, 4'd8, 16'h0001, 16'hA008};
        tbl[10] = '{1'b1, 4'd9, 16'h0003, 4'd9, 4'd15, 16'h0002, 16'hA00F};
        tbl[11] = '{1'b0, 4'd9, 16'h0000, 4'd9, 4'd7, 16'h0003, 16'hA007};

        #1;
        rd_addr0 = 4'd3;
        rd_addr1 = 4'd9;
        expect2(0, 16'h0000, 16'h0000);
        drain("reset_state");
        cmp("reset_b", 0, b_data0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i < 16; i++) apply(1'b1, 4'(i), 16'hA000 + 16'(i), 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 4'd0, 16'd0, 4'(i), 4'(15 - i));
            expect2(i, (i == 0) ? 16'h0000 : 16'hA000 + 16'(i),
                    (i == 15) ? 16'h0000 : 16'hA000 + 16'(15 - i));
            drain("sweep");
        end

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a0, tbl[i].a1);
            expect2(i, tbl[i].e0, tbl[i].e1);
            drain("table");
        end

        apply(1'b0, 4'd0, 16'd0, 4'd0, 4'd5);
        #0.1;
        cmp("zero_off_wr0", 0, b_data0, 16'hFFFF);
        cmp("zero_on_wr0", 0, rd_data0, 16'h0000);

        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr0 = 4'(i);
            rd_addr1 = 4'(15 - i);
            expect2(i, 16'h0000, 16'h0000);
            drain("async_rst");
        end
        cmp("async_rst_b", 0, b_data1, 16'h0000);
        rst = 1'b0;

        apply(1'b1, 4'd3, 16'h3333, 4'd3, 4'd4);
        apply(1'b1, 4'd4, 16'h4444, 4'd3, 4'd4);
        expect2(0, 16'h3333, 16'h0000);
        drain("mid_pre");
        #1;
        rst = 1'b1;
        expect2(1, 16'h0000, 16'h0000);
        drain("mid_rst");
        apply(1'b0, 4'd0, 16'd0, 4'd3, 4'd4);
        rst = 1'b0;
        apply(1'b0, 4'd0, 16'd0, 4'd3, 4'd4);
        expect2(2, 16'h0000, 16'h0000);
        drain("mid_lost");
        apply(1'b1, 4'd4, 16'h0042, 4'd3, 4'd4);
        apply(1'b0, 4'd0, 16'd0, 4'd3, 4'd4);
        expect2(3, 16'h0000, 16'h0042);
        drain("mid_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
